// File: rtl/csa_seq_multiplier.sv
// Iterative carry-save multiplier: BITS_PER_CYCLE partial products per cycle are
// folded into redundant sum/carry registers, then a single carry-propagate add resolves.
module csa_seq_multiplier #(
  parameter int BIT_WIDTH      = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   start,
  input  logic [1:0]             is_signed,
  input  logic [BIT_WIDTH-1:0]   multiplicand,
  input  logic [BIT_WIDTH-1:0]   multiplier,
  output logic                   busy,
  output logic                   finished,
  output logic [2*BIT_WIDTH-1:0] product
);

  localparam int PW   = 2 * BIT_WIDTH;
  localparam int ITER = BIT_WIDTH / BITS_PER_CYCLE;
  localparam int CW   = (ITER < 2) ? 1 : $clog2(ITER);
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t                 state;
  logic [PW-1:0]          a_sh;
  logic [BIT_WIDTH-1:0]   b_q;
  logic [PW-1:0]          sum_q;
  logic [PW-1:0]          carry_q;
  logic [CW-1:0]          cnt;
  logic                   neg;

  logic                   a_neg;
  logic                   b_neg;
  logic [BIT_WIDTH-1:0]   a_mag;
  logic [BIT_WIDTH-1:0]   b_mag;
  logic                   zero_op;
  logic [PW-1:0]          pp;
  logic [PW-1:0]          t_sum;
  logic [PW-1:0]          t_carry;
  logic [PW-1:0]          nxt_sum;
  logic [PW-1:0]          nxt_carry;
  logic [PW-1:0]          resolved;

  // The most negative operand negates to itself, which is exactly its unsigned magnitude.
  assign a_neg   = is_signed[1] & multiplicand[BIT_WIDTH-1];
  assign b_neg   = is_signed[0] & multiplier[BIT_WIDTH-1];
  assign a_mag   = a_neg ? -multiplicand : multiplicand;
  assign b_mag   = b_neg ? -multiplier : multiplier;
  assign zero_op = (multiplicand == '0) || (multiplier == '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    nxt_sum   = sum_q;
    nxt_carry = carry_q;
    pp        = '0;
    t_sum     = '0;
    t_carry   = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      pp        = (a_sh << j) & {PW{b_q[j]}};
      t_sum     = nxt_sum ^ nxt_carry ^ pp;
      t_carry   = ((nxt_sum & nxt_carry) | (nxt_sum & pp) | (nxt_carry & pp)) << 1;
      nxt_sum   = t_sum;
      nxt_carry = t_carry;
    end
  end

  assign resolved = sum_q + carry_q;

  // NOTE: all state, including the wide datapath registers, is reset so an aborted operation
  // leaves nothing behind; sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      product  <= '0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= {{BIT_WIDTH{1'b0}}, a_mag};
            b_q     <= b_mag;
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
            if (zero_op) begin
              neg   <= 1'b0;
              state <= RESOLVE;
            end else begin
              neg   <= a_neg ^ b_neg;
              busy  <= 1'b1;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          sum_q   <= nxt_sum;
          carry_q <= nxt_carry;
          a_sh    <= a_sh << BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            busy  <= 1'b0;
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          product  <= neg ? -resolved : resolved;
          finished <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Drives three multiplier instances (4, 1 and 8 bits per cycle) with shared stimulus and
// checks each against an arithmetic model of product value and completion timing.
module tb_csa_seq_multiplier;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  is_signed = 2'b00;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [2:0]  busy_v;
  logic [2:0]  fin_v;
  logic [63:0] prod_v [3];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(negedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = s[1] ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s[0] ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    localparam int IT  = 32 / BPC;

    csa_seq_multiplier #(.BIT_WIDTH(32), .BITS_PER_CYCLE(BPC)) u_dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .start       (start),
      .is_signed   (is_signed),
      .multiplicand(multiplicand),
      .multiplier  (multiplier),
      .busy        (busy_v[g]),
      .finished    (fin_v[g]),
      .product     (prod_v[g])
    );

    bit          active = 1'b0;
    int          remaining = 0;
    bit          exp_busy = 1'b0;
    bit          exp_fin = 1'b0;
    logic [63:0] exp_prod = '0;
    logic [63:0] pend = '0;
    int          st_cyc = -1;
    int          last_st = -1;
    int          lat = 0;
    int          bcnt = 0;

    // Model: an accepted request completes after a fixed number of edges with the true product.
    always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        active    = 1'b0;
        remaining = 0;
        exp_busy  = 1'b0;
        exp_fin   = 1'b0;
        exp_prod  = '0;
      end else begin
        exp_fin = 1'b0;
        if (active) begin
          remaining--;
          if (remaining == 0) begin
            active   = 1'b0;
            exp_prod = pend;
            exp_fin  = 1'b1;
            lat      = cyc - st_cyc;
          end
        end else if (start) begin
          pend      = ref_mul(is_signed, multiplicand, multiplier);
          remaining = (multiplicand == 0 || multiplier == 0) ? 1 : IT + 1;
          active    = 1'b1;
          st_cyc    = cyc;
        end
        exp_busy = active && (remaining >= 2);
      end
    end

    always @(negedge CLK) begin
      if (st_cyc != last_st) begin
        bcnt    = 0;
        last_st = st_cyc;
      end
      if (busy_v[g] === 1'b1) bcnt++;
      check($sformatf("busy_bpc%0d", BPC), 64'(busy_v[g]), 64'(exp_busy));
      check($sformatf("finished_bpc%0d", BPC), 64'(fin_v[g]), 64'(exp_fin));
      check($sformatf("product_bpc%0d", BPC), prod_v[g], exp_prod);
    end
  end

  typedef struct {
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    bit          zero;
    bit          poke;
  } vec_t;

  vec_t vecs [7] = '{
    '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1},
    '{2'b11, 32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0},
    '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0},
    '{2'b11, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0},
    '{2'b11, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0},
    '{2'b11, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 1'b1, 1'b0},
    '{2'b01, 32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0}
  };

  int lit_lat  [3] = '{9, 33, 5};
  int lit_busy [3] = '{8, 32, 4};

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic bit all_idle();
    return !g_dut[0].active && !g_dut[1].active && !g_dut[2].active;
  endfunction

  task automatic wait_all_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (all_idle()) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({name, "_timeout"}, 64'(ok), 64'(1));
  endtask

  task automatic check_inst(input int g, input string name, input int lat, input int bcnt,
                            input logic [63:0] mprod, input logic [63:0] lit, input bit zero);
    check($sformatf("%s_model%0d", name, g), mprod, lit);
    check($sformatf("%s_prod%0d", name, g), prod_v[g], lit);
    check($sformatf("%s_lat%0d", name, g), 64'(lat), 64'(zero ? 1 : lit_lat[g]));
    check($sformatf("%s_busycyc%0d", name, g), 64'(bcnt), 64'(zero ? 0 : lit_busy[g]));
  endtask

  task automatic run_directed(input string name, input vec_t v);
    wait_all_idle({name, "_pre"});
    start        = 1'b1;
    is_signed    = v.s;
    multiplicand = v.a;
    multiplier   = v.b;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    if (v.poke) begin
      tick();
      tick();
      start        = 1'b1;
      is_signed    = 2'b00;
      multiplicand = 32'd5;
      multiplier   = 32'd5;
      tick();
      start = 1'b0;
    end
    wait_all_idle(name);
    check_inst(0, name, g_dut[0].lat, g_dut[0].bcnt, g_dut[0].exp_prod, v.p, v.zero);
    check_inst(1, name, g_dut[1].lat, g_dut[1].bcnt, g_dut[1].exp_prod, v.p, v.zero);
    check_inst(2, name, g_dut[2].lat, g_dut[2].bcnt, g_dut[2].exp_prod, v.p, v.zero);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 nRST = 1'b0;
    tick();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_busy%0d", g), 64'(busy_v[g]), 64'(0));
      check($sformatf("rst_fin%0d", g), 64'(fin_v[g]), 64'(0));
      check($sformatf("rst_prod%0d", g), prod_v[g], 64'h0);
    end
    tick();
    nRST = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_directed($sformatf("dir%0d", i), vecs[i]);

    // Abort a long operation after a nonzero product is already held.
    start        = 1'b1;
    is_signed    = 2'b00;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    nRST = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("abort_busy%0d", g), 64'(busy_v[g]), 64'(0));
      check($sformatf("abort_fin%0d", g), 64'(fin_v[g]), 64'(0));
      check($sformatf("abort_prod%0d", g), prod_v[g], 64'h0);
    end
    tick();
    tick();
    nRST = 1'b1;
    tick();
    run_directed("post_rst", '{2'b00, 32'h0000_1234, 32'h0000_5678,
                               64'h0000_0000_0626_0060, 1'b0, 1'b0});

    for (int c = 0; c < 2500; c++) begin
      start        = ($urandom_range(0, 3) == 0);
      is_signed    = 2'($urandom);
      multiplicand = pick();
      multiplier   = pick();
      nRST         = ($urandom_range(0, 499) != 0);
      tick();
    end
    nRST  = 1'b1;
    start = 1'b0;
    wait_all_idle("drain");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
